ctrl_pipe_unit: RTL and testbench

// Parametrised successor to the decode-stage control unit. It decodes op/funct in D
// (R, I-ALU, load, store, branch) and carries the control bundle through the ID/EX,
// EX/MEM and MEM/WB pipeline registers. It also handles three hazards: load-use stall,

---
 rtl/ctrl_pipe_unit.sv | 181 ++++++++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_unit.sv
// ctrl_pipe_unit: decode-stage control with ID/EX, EX/MEM, MEM/WB
// control registers, load-use stall, branch flush and EX forwarding.
module ctrl_pipe_unit #(
  parameter int ALU_CTRL_W = 3,
  parameter int REG_ADDR_W = 5,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_d,
  input  logic [6:0]            op_d,
  input  logic [2:0]            funct_d,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic                  br_taken_e,
  output logic                  sel_imm_d,
  output logic                  illegal_d,
  output logic                  stall_d,
  output logic                  flush_d,
  output logic                  valid_e,
  output logic                  regwrite_e,
  output logic                  alusrc_e,
  output logic                  branch_e,
  output logic [1:0]            memctrl_e,
  output logic [ALU_CTRL_W-1:0] aluctrl_e,
  output logic [REG_ADDR_W-1:0] rd_e,
  output logic [1:0]            fwd_a_e,
  output logic [1:0]            fwd_b_e,
  output logic                  regwrite_m,
  output logic [1:0]            memctrl_m,
  output logic                  memtoreg_m,
  output logic [REG_ADDR_W-1:0] rd_m,
  output logic                  regwrite_w,
  output logic                  memtoreg_w,
  output logic [REG_ADDR_W-1:0] rd_w
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic                  alusrc;
    logic                  branch;
    logic [1:0]            memctrl;
    logic                  memtoreg;
    logic [ALU_CTRL_W-1:0] alu;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
  } id_ex_t;

  typedef struct packed {
    logic                  regwrite;
    logic [1:0]            memctrl;
    logic                  memtoreg;
    logic [REG_ADDR_W-1:0] rd;
  } ex_mem_t;

  typedef struct packed {
    logic                  regwrite;
    logic                  memtoreg;
    logic [REG_ADDR_W-1:0] rd;
  } mem_wb_t;

  id_ex_t  id_ex_d, id_ex_q, dec;
  ex_mem_t ex_mem_d, ex_mem_q;
  mem_wb_t mem_wb_d, mem_wb_q;

  logic                  legal;
  logic                  load_use;
  logic                  rd_e_live;
  logic [ALU_CTRL_W-1:0] fn_ext;

  assign fn_ext = ALU_CTRL_W'(funct_d);

  always_comb begin
    dec   = '0;
    legal = 1'b1;
    unique case (1'b1)
      (op_d == OP_R): begin
        dec.regwrite = 1'b1;
        dec.alu      = fn_ext;
      end
      (op_d == OP_I): begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.alu      = fn_ext;
      end
      (op_d == OP_LD): begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.memctrl  = 2'b10;
        dec.memtoreg = 1'b1;
      end
      (op_d == OP_ST): begin
        dec.alusrc  = 1'b1;
        dec.memctrl = 2'b11;
      end
      (op_d == OP_BR): begin
        dec.branch = 1'b1;
        dec.alu    = fn_ext;
      end
      default: legal = 1'b0;
    endcase
    dec.valid = valid_d;
    dec.rd    = rd_d;
    dec.rs1   = rs1_d;
    dec.rs2   = rs2_d;
  end

  assign sel_imm_d = (op_d == OP_ST);
  assign illegal_d = valid_d & ~legal;

  assign rd_e_live = !ZERO_REG || (id_ex_q.rd != '0);
  assign load_use  = valid_d && id_ex_q.valid
                  && (id_ex_q.memctrl == 2'b10) && rd_e_live
                  && ((id_ex_q.rd == rs1_d) || (id_ex_q.rd == rs2_d));

  // A taken branch kills D anyway, so it overrides the stall.
  assign flush_d = id_ex_q.branch & br_taken_e;
  assign stall_d = load_use & ~flush_d;

  always_comb begin
    id_ex_d = dec;
    if (flush_d || stall_d || !valid_d || illegal_d) id_ex_d = '0;
    ex_mem_d = '{regwrite: id_ex_q.regwrite, memctrl: id_ex_q.memctrl,
                 memtoreg: id_ex_q.memtoreg, rd: id_ex_q.rd};
    mem_wb_d = '{regwrite: ex_mem_q.regwrite,
                 memtoreg: ex_mem_q.memtoreg, rd: ex_mem_q.rd};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q  <= '0;
      ex_mem_q <= '0;
      mem_wb_q <= '0;
    end else begin
      id_ex_q  <= id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;
    end
  end

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input ex_mem_t               m,
    input mem_wb_t               w
  );
    logic m_hit, w_hit;
    m_hit = m.regwrite && (m.rd == rs) && (!ZERO_REG || m.rd != '0);
    w_hit = w.regwrite && (w.rd == rs) && (!ZERO_REG || w.rd != '0);
    if (m_hit) return 2'b10;
    if (w_hit) return 2'b01;
    return 2'b00;
  endfunction

  assign fwd_a_e = fwd_sel(id_ex_q.rs1, ex_mem_q, mem_wb_q);
  assign fwd_b_e = fwd_sel(id_ex_q.rs2, ex_mem_q, mem_wb_q);

  assign valid_e    = id_ex_q.valid;
  assign regwrite_e = id_ex_q.regwrite;
  assign alusrc_e   = id_ex_q.alusrc;
  assign branch_e   = id_ex_q.branch;
  assign memctrl_e  = id_ex_q.memctrl;
  assign aluctrl_e  = id_ex_q.alu;
  assign rd_e       = id_ex_q.rd;
  assign regwrite_m = ex_mem_q.regwrite;
  assign memctrl_m  = ex_mem_q.memctrl;
  assign memtoreg_m = ex_mem_q.memtoreg;
  assign rd_m       = ex_mem_q.rd;
  assign regwrite_w = mem_wb_q.regwrite;
  assign memtoreg_w = mem_wb_q.memtoreg;
  assign rd_w       = mem_wb_q.rd;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// tb_ctrl_pipe_unit: scoreboard bench for ctrl_pipe_unit against an
// instruction-level model of the decode table and pipeline hazards.
module tb_ctrl_pipe_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid_d;
  logic [6:0] op_d;
  logic [2:0] funct_d;
  logic [4:0] rs1_d, rs2_d, rd_d;
  logic       br_taken_e;
  logic       sel_imm_d, illegal_d, stall_d, flush_d;
  logic       valid_e, regwrite_e, alusrc_e, branch_e;
  logic [1:0] memctrl_e;
  logic [2:0] aluctrl_e;
  logic [4:0] rd_e;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic       regwrite_m, memtoreg_m;
  logic [1:0] memctrl_m;
  logic [4:0] rd_m;
  logic       regwrite_w, memtoreg_w;
  logic [4:0] rd_w;

  ctrl_pipe_unit dut (
    .clk(clk), .rst_n(rst_n), .valid_d(valid_d), .op_d(op_d),
    .funct_d(funct_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .br_taken_e(br_taken_e), .sel_imm_d(sel_imm_d),
    .illegal_d(illegal_d), .stall_d(stall_d), .flush_d(flush_d),
    .valid_e(valid_e), .regwrite_e(regwrite_e), .alusrc_e(alusrc_e),
    .branch_e(branch_e), .memctrl_e(memctrl_e), .aluctrl_e(aluctrl_e),
    .rd_e(rd_e), .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
    .regwrite_m(regwrite_m), .memctrl_m(memctrl_m),
    .memtoreg_m(memtoreg_m), .rd_m(rd_m), .regwrite_w(regwrite_w),
    .memtoreg_w(memtoreg_w), .rd_w(rd_w)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef struct packed {
    bit       valid, rw, asrc, br;
    bit [1:0] mem;
    bit       m2r;
    bit [2:0] alu;
    bit [4:0] rd, rs1, rs2;
  } ctl_t;

  typedef struct packed {
    logic [3:0]  comb;
    logic [13:0] ebus;
    logic [3:0]  fwd;
    logic [8:0]  mbus;
    logic [6:0]  wbus;
  } exp_t;

  ctl_t e_s, m_s, w_s;
  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic ctl_t model_dec(input logic [6:0] op,
                                     input logic [2:0] fn,
                                     output bit legal);
    ctl_t c = '0;
    legal = 1'b1;
    case (op)
      R:  begin c.rw = 1; c.alu = fn; end
      I:  begin c.rw = 1; c.asrc = 1; c.alu = fn; end
      LD: begin c.rw = 1; c.asrc = 1; c.mem = 2'b10; c.m2r = 1; end
      ST: begin c.asrc = 1; c.mem = 2'b11; end
      BR: begin c.br = 1; c.alu = fn; end
      default: legal = 1'b0;
    endcase
    return c;
  endfunction

  // Newest writer wins: the instruction in M is younger than the one in W.
  function automatic logic [1:0] src(input logic [4:0] r);
    if (m_s.rw && m_s.rd != 0 && m_s.rd == r) return 2'b10;
    if (w_s.rw && w_s.rd != 0 && w_s.rd == r) return 2'b01;
    return 2'b00;
  endfunction

  task automatic step(input bit v, input logic [6:0] op,
                      input logic [2:0] fn, input logic [4:0] r1,
                      input logic [4:0] r2, input logic [4:0] rd,
                      input bit bt, output bit st);
    ctl_t d;
    bit   legal, ill, fl, lu;
    exp_t x;
    valid_d = v; op_d = op; funct_d = fn;
    rs1_d = r1; rs2_d = r2; rd_d = rd; br_taken_e = bt;
    d = model_dec(op, fn, legal);
    d.valid = v; d.rd = rd; d.rs1 = r1; d.rs2 = r2;
    ill = v && !legal;
    fl  = e_s.br && bt;
    lu  = v && e_s.valid && e_s.mem == 2'b10 && e_s.rd != 0
       && (e_s.rd == r1 || e_s.rd == r2);
    st  = lu && !fl;
    x.comb = {st, fl, ill, op == ST};
    x.ebus = {e_s.valid, e_s.rw, e_s.asrc, e_s.br, e_s.mem,
              e_s.alu, e_s.rd};
    x.fwd  = {src(e_s.rs1), src(e_s.rs2)};
    x.mbus = {m_s.rw, m_s.mem, m_s.m2r, m_s.rd};
    x.wbus = {w_s.rw, w_s.m2r, w_s.rd};
    sb.push_back(x);
    w_s = m_s;
    m_s = e_s;
    e_s = (fl || st || !v || ill) ? ctl_t'(0) : d;
    @(posedge clk);
    #1;
  endtask

  // The fetch side re-presents a stalled instruction until it is accepted.
  task automatic issue(input bit v, input logic [6:0] op,
                       input logic [2:0] fn, input logic [4:0] r1,
                       input logic [4:0] r2, input logic [4:0] rd,
                       input bit bt, output int nst);
    bit st;
    nst = 0;
    for (int k = 0; k < 4; k++) begin
      step(v, op, fn, r1, r2, rd, bt, st);
      if (!st) break;
      nst++;
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t x;
      x = sb.pop_front();
      chk("comb", {stall_d, flush_d, illegal_d, sel_imm_d}, x.comb);
      chk("e_bus", {valid_e, regwrite_e, alusrc_e, branch_e, memctrl_e,
                    aluctrl_e, rd_e}, x.ebus);
      chk("fwd", {fwd_a_e, fwd_b_e}, x.fwd);
      chk("m_bus", {regwrite_m, memctrl_m, memtoreg_m, rd_m}, x.mbus);
      chk("w_bus", {regwrite_w, memtoreg_w, rd_w}, x.wbus);
    end
  end

  task automatic chk_regs_zero(input string nm);
    chk({nm, "_e"}, {valid_e, regwrite_e, alusrc_e, branch_e, memctrl_e,
                     aluctrl_e, rd_e}, 0);
    chk({nm, "_m"}, {regwrite_m, memctrl_m, memtoreg_m, rd_m}, 0);
    chk({nm, "_w"}, {regwrite_w, memtoreg_w, rd_w}, 0);
    chk({nm, "_fwd"}, {fwd_a_e, fwd_b_e}, 0);
  endtask

  task automatic rand_run(input int n);
    logic [6:0] ops [6];
    int nst;
    ops = '{R, I, LD, ST, BR, BAD};
    for (int i = 0; i < n; i++) begin
      logic [6:0] op;
      op = ops[$urandom_range(0, 5)];
      if ($urandom_range(0, 15) == 0) op = 7'($urandom);
      issue($urandom_range(0, 7) != 0, op, 3'($urandom),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), nst);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nst;
    bit st;
    e_s = '0; m_s = '0; w_s = '0;
    rst_n = 1'b0; valid_d = 0; op_d = 0; funct_d = 0;
    rs1_d = 0; rs2_d = 0; rd_d = 0; br_taken_e = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_regs_zero("reset");
    rst_n = 1'b1;

    issue(1, R, 3'b000, 5'd0, 5'd0, 5'd1, 0, nst);
    issue(1, R, 3'b000, 5'd1, 5'd0, 5'd2, 0, nst);
    chk("fwd_m", fwd_a_e, 2'b10);
    issue(1, R, 3'b000, 5'd0, 5'd0, 5'd1, 0, nst);
    issue(1, I, 3'b001, 5'd0, 5'd0, 5'd3, 0, nst);
    issue(1, R, 3'b000, 5'd1, 5'd0, 5'd2, 0, nst);
    chk("fwd_w", fwd_a_e, 2'b01);

    issue(1, LD, 3'b010, 5'd0, 5'd0, 5'd5, 0, nst);
    issue(1, R, 3'b000, 5'd5, 5'd7, 5'd6, 0, nst);
    chk("ldu_stalls", nst, 1);
    chk("ldu_fwd", {valid_e, fwd_a_e}, 3'b101);

    issue(1, BR, 3'b000, 5'd1, 5'd2, 5'd0, 0, nst);
    issue(1, R, 3'b000, 5'd0, 5'd0, 5'd4, 1, nst);
    chk("flush_nostall", nst, 0);
    chk("flush_bubble", {valid_e, rd_e}, 0);

    issue(1, ST, 3'b010, 5'd1, 5'd2, 5'd0, 0, nst);
    chk("st_e", {memctrl_e, aluctrl_e, regwrite_e}, 6'b11_000_0);
    step(0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0, 0, st);
    chk("st_m", memctrl_m, 2'b11);

    issue(1, BAD, 3'b000, 5'd1, 5'd1, 5'd4, 0, nst);
    chk("ill_bubble", {valid_e, rd_e}, 0);
    issue(1, LD, 3'b000, 5'd1, 5'd0, 5'd0, 0, nst);
    issue(1, R, 3'b000, 5'd0, 5'd0, 5'd3, 0, nst);
    chk("x0_nostall", nst, 0);

    rand_run(150);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_regs_zero("midreset");
    e_s = '0; m_s = '0; w_s = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("post_reset_fwd", {fwd_a_e, fwd_b_e}, 0);

    rand_run(250);
    @(negedge clk);
    #1;
    chk("sb_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
